// File: rtl/control_pipeline.sv
// Pipelined MIPS control: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall, EX redirect flush and saturating counters.
// Optional macro LOAD_USE_STALL_EN enables load-use hazard detection.
module control_pipeline #(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                ex_redirect,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                ifid_flush,
    output logic                ex_reg_dst,
    output logic                ex_alu_src,
    output logic                ex_zero_extnd,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic [1:0]          ex_alu_op,
    output logic                ex_illegal,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       zero_extnd;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(43);
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ORI = OPCODE_W'(13);

    ctrl_t            dec;
    logic             rt_used;
    logic             hazard;
    logic             stall;
    logic             bubble;

    ctrl_t            idex_ctrl_q, idex_ctrl_d;
    logic [REG_W-1:0] idex_rt_q, idex_rt_d;
    logic [3:0]       exmem_q, exmem_d;
    logic [1:0]       memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Opcode decode; unknown opcodes produce no controls and flag illegal
    always_comb begin
        dec     = '0;
        rt_used = 1'b0;
        case (id_opcode)
            OP_R: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                rt_used       = 1'b1;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                rt_used       = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
                rt_used    = 1'b1;
            end
            OP_J: begin
                dec.jump   = 1'b1;
                dec.alu_op = 2'b01;
            end
            OP_ORI: begin
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = 2'b11;
                dec.zero_extnd = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

`ifdef LOAD_USE_STALL_EN
    assign hazard = id_valid & idex_ctrl_q.mem_read
                  & (idex_rt_q != '0)
                  & ((idex_rt_q == id_rs)
                     | (rt_used & (idex_rt_q == id_rt)));
`else
    // Software schedules around loads; these inputs are only
    // needed by the hazard detector.
    logic unused_hz;
    assign unused_hz = ^{id_rs, idex_rt_q, rt_used};
    assign hazard    = 1'b0;
`endif

    assign stall      = hazard & ~ex_redirect;
    assign bubble     = stall | ex_redirect | ~id_valid;
    assign pc_write   = rst | ~stall;
    assign ifid_write = rst | ~stall;
    assign ifid_flush = ex_redirect & ~rst;

    // Next-state for the pipeline control registers and counters
    always_comb begin
        idex_ctrl_d = bubble ? '0 : dec;
        idex_rt_d   = bubble ? '0 : id_rt;
        exmem_d     = {idex_ctrl_q.mem_read, idex_ctrl_q.mem_write,
                       idex_ctrl_q.reg_write, idex_ctrl_q.mem_to_reg};
        memwb_d     = exmem_q[1:0];
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ex_redirect && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Pipeline and counter registers; reset empties the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_ctrl_q <= '0;
            idex_rt_q   <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_ctrl_q <= idex_ctrl_d;
            idex_rt_q   <= idex_rt_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_reg_dst    = idex_ctrl_q.reg_dst;
    assign ex_alu_src    = idex_ctrl_q.alu_src;
    assign ex_zero_extnd = idex_ctrl_q.zero_extnd;
    assign ex_branch     = idex_ctrl_q.branch;
    assign ex_jump       = idex_ctrl_q.jump;
    assign ex_alu_op     = idex_ctrl_q.alu_op;
    assign ex_illegal    = idex_ctrl_q.illegal;
    assign mem_read      = exmem_q[3];
    assign mem_write     = exmem_q[2];
    assign wb_reg_write  = memwb_q[1];
    assign wb_mem_to_reg = memwb_q[0];
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline (counters narrowed to 2 bits).
// Expected rows are hand-computed per cycle; a monitor checks each one.
module tb_control_pipeline;

    localparam int CW = 2;
`ifdef LOAD_USE_STALL_EN
    localparam logic SE = 1'b1;
`else
    localparam logic SE = 1'b0;
`endif
    localparam logic [5:0] R_ = 6'd0;
    localparam logic [5:0] LW = 6'd35;
    localparam logic [5:0] SW = 6'd43;
    localparam logic [5:0] BQ = 6'd4;
    localparam logic [5:0] JJ = 6'd2;
    localparam logic [5:0] OI = 6'd13;
    localparam logic [5:0] IL = 6'd63;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [5:0]    id_opcode = '0;
    logic [4:0]    id_rs = '0;
    logic [4:0]    id_rt = '0;
    logic          ex_redirect = 1'b0;
    logic          pc_write, ifid_write, ifid_flush;
    logic          ex_reg_dst, ex_alu_src, ex_zero_extnd;
    logic          ex_branch, ex_jump, ex_illegal;
    logic [1:0]    ex_alu_op;
    logic          mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
    logic [CW-1:0] stall_cnt, flush_cnt;

    control_pipeline #(.OPCODE_W(6), .REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_redirect(ex_redirect), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
        .ex_zero_extnd(ex_zero_extnd), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
        .ex_illegal(ex_illegal), .mem_read(mem_read),
        .mem_write(mem_write), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       pcw, ifw, ifl;
        logic [7:0] ex;
        logic [1:0] mem, wb, sc, fc;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input int c, input string n,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cyc %0d %s: got %h expected %h", c, n, act, exp);
        end
    endtask

    // ex word: {reg_dst,alu_src,zext,branch,jump,alu_op[1:0],illegal}
    // mem: {mem_read,mem_write}  wb: {reg_write,mem_to_reg}
    task automatic step(input int c, input logic r, input logic v,
                        input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic rd,
                        input logic pcw, input logic ifw, input logic ifl,
                        input logic [7:0] ex, input logic [1:0] mem,
                        input logic [1:0] wb, input logic [1:0] sc,
                        input logic [1:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_opcode = op;
        id_rs = rs; id_rt = rt; ex_redirect = rd;
        e.cyc = c; e.pcw = pcw; e.ifw = ifw; e.ifl = ifl;
        e.ex = ex; e.mem = mem; e.wb = wb; e.sc = sc; e.fc = fc;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            chk(me.cyc, "pc_write", {7'd0, pc_write}, {7'd0, me.pcw});
            chk(me.cyc, "ifid_write", {7'd0, ifid_write}, {7'd0, me.ifw});
            chk(me.cyc, "ifid_flush", {7'd0, ifid_flush}, {7'd0, me.ifl});
            chk(me.cyc, "ex_ctrl",
                {ex_reg_dst, ex_alu_src, ex_zero_extnd, ex_branch,
                 ex_jump, ex_alu_op, ex_illegal}, me.ex);
            chk(me.cyc, "mem_ctrl", {6'd0, mem_read, mem_write},
                {6'd0, me.mem});
            chk(me.cyc, "wb_ctrl", {6'd0, wb_reg_write, wb_mem_to_reg},
                {6'd0, me.wb});
            chk(me.cyc, "stall_cnt", {6'd0, stall_cnt}, {6'd0, me.sc});
            chk(me.cyc, "flush_cnt", {6'd0, flush_cnt}, {6'd0, me.fc});
        end
    end

    logic       hz_n;
    logic [1:0] s1, s2;
    logic [7:0] ex_c8, ex_c34;
    logic [1:0] wb_c10, mem_c35;

    initial begin
        hz_n   = ~SE;
        s1     = SE ? 2'd1 : 2'd0;
        s2     = SE ? 2'd2 : 2'd0;
        ex_c8  = SE ? 8'h00 : 8'h84;
        ex_c34 = SE ? 8'h00 : 8'h40;
        wb_c10 = SE ? 2'b00 : 2'b10;
        mem_c35 = SE ? 2'b00 : 2'b01;
        //   c  rst v op  rs rt rd pcw  ifw  ifl ex     mem wb  sc fc
        step(0, 1, 0, R_, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0);
        step(1, 0, 1, LW, 1, 9, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
        step(2, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h40, 0, 0, 0, 0);
        step(3, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, 0, 0);
        step(4, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 3, 0, 0);
        step(5, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
        // load-use on rs
        step(6, 0, 1, LW, 0, 8, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
        step(7, 0, 1, R_, 8, 3, 0, hz_n, hz_n, 0, 8'h40, 0, 0, 0, 0);
        step(8, 0, 1, R_, 8, 3, 0, 1, 1, 0, ex_c8, 2, 0, s1, 0);
        step(9, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h84, 0, 3, s1, 0);
        step(10, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, wb_c10, s1, 0);
        step(11, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 2, s1, 0);
        // load into r0 never stalls
        step(12, 0, 1, LW, 2, 0, 0, 1, 1, 0, 8'h00, 0, 0, s1, 0);
        step(13, 0, 1, R_, 0, 0, 0, 1, 1, 0, 8'h40, 0, 0, s1, 0);
        step(14, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h84, 2, 0, s1, 0);
        step(15, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 3, s1, 0);
        step(16, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 2, s1, 0);
        // redirect beats a simultaneous hazard
        step(17, 0, 1, LW, 0, 8, 0, 1, 1, 0, 8'h00, 0, 0, s1, 0);
        step(18, 0, 1, R_, 8, 1, 1, 1, 1, 1, 8'h40, 0, 0, s1, 0);
        step(19, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 2, 0, s1, 1);
        step(20, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 3, s1, 1);
        step(21, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, s1, 1);
        // illegal then ORI
        step(22, 0, 1, IL, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, s1, 1);
        step(23, 0, 1, OI, 4, 5, 0, 1, 1, 0, 8'h01, 0, 0, s1, 1);
        step(24, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h66, 0, 0, s1, 1);
        step(25, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, s1, 1);
        step(26, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 2, s1, 1);
        // SW, BEQ, J
        step(27, 0, 1, SW, 1, 2, 0, 1, 1, 0, 8'h00, 0, 0, s1, 1);
        step(28, 0, 1, BQ, 1, 2, 0, 1, 1, 0, 8'h40, 0, 0, s1, 1);
        step(29, 0, 1, JJ, 0, 0, 0, 1, 1, 0, 8'h12, 1, 0, s1, 1);
        step(30, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h0A, 0, 0, s1, 1);
        step(31, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, s1, 1);
        // load-use through rt of a store
        step(32, 0, 1, LW, 0, 7, 0, 1, 1, 0, 8'h00, 0, 0, s1, 1);
        step(33, 0, 1, SW, 0, 7, 0, hz_n, hz_n, 0, 8'h40, 0, 0, s1, 1);
        step(34, 0, 1, SW, 0, 7, 0, 1, 1, 0, ex_c34, 2, 0, s2, 1);
        step(35, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h40, mem_c35, 3, s2, 1);
        step(36, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 1, 0, s2, 1);
        // ORI does not read rt, so no stall
        step(37, 0, 1, LW, 0, 7, 0, 1, 1, 0, 8'h00, 0, 0, s2, 1);
        step(38, 0, 1, OI, 0, 7, 0, 1, 1, 0, 8'h40, 0, 0, s2, 1);
        step(39, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h66, 2, 0, s2, 1);
        step(40, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 3, s2, 1);
        step(41, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 2, s2, 1);
        // flush counter saturation
        step(42, 1, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
        step(43, 0, 0, R_, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 0);
        step(44, 0, 0, R_, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1);
        step(45, 0, 0, R_, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 2);
        step(46, 0, 0, R_, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 3);
        step(47, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 3);
        // reset while a load sits in ID/EX
        step(48, 0, 1, LW, 0, 8, 0, 1, 1, 0, 8'h00, 0, 0, 0, 3);
        step(49, 1, 1, R_, 8, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
        step(50, 0, 1, R_, 8, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
        step(51, 0, 0, R_, 0, 0, 0, 1, 1, 0, 8'h84, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sbq.size() > 0; i++)
            @(posedge clk);
        @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d rows left, expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
# control_pipeline

Pipelined successor to the single-cycle MIPS control decoder. It decodes the ID-stage opcode, then carries the control bits through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, stalling PC and IF/ID and inserting bubbles, and applies branch/jump flushes from EX. Saturating stall and flush counters are included for performance measurement.

## Interface
Parameters:
- OPCODE_W, 6, opcode field width
- REG_W, 5, register-specifier width
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  the ID stage holds a real instruction
- id_opcode  in  OPCODE_W  opcode of the ID instruction
- id_rs, id_rt  in  REG_W  source specifiers of the ID instruction
- ex_redirect  in  1  EX has resolved a taken branch or a jump
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID
- ex_reg_dst, ex_alu_src, ex_zero_extnd, ex_branch, ex_jump  out  1 each  EX controls
- ex_alu_op  out  2  ALU control
- ex_illegal  out  1  the EX instruction had an unimplemented opcode
- mem_read, mem_write  out  1 each  MEM controls
- wb_reg_write, wb_mem_to_reg  out  1 each  WB controls
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
Decode table (combinational; every field not listed below is 0):
- R-format, opcode 0: reg_dst=1, reg_write=1, alu_op=10.
- LW, opcode 35: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
- SW, opcode 43: alu_src=1, mem_write=1, alu_op=00.
- BEQ, opcode 4: branch=1, alu_op=01.
- J, opcode 2: jump=1, alu_op=01.
- ORI, opcode 13: alu_src=1, reg_write=1, alu_op=11, zero_extnd=1.
- Any other opcode: all controls 0 and illegal=1. X values are never driven.

Hazard and flush rules:
- rt_used = 1 for R-format, SW and BEQ; 0 otherwise.
- hazard = id_valid & ID/EX.mem_read & (ID/EX.rt != 0) & (ID/EX.rt == id_rs | (rt_used & ID/EX.rt == id_rt)).
- With a hazard and no ex_redirect: pc_write=0, ifid_write=0, and ID/EX loads a bubble.
- With ex_redirect: ifid_flush=1, ID/EX loads a bubble, pc_write=1 and ifid_write=1. The redirect wins over a simultaneous hazard, and stall_cnt does not increment in that case.
- When id_valid=0, ID/EX loads a bubble.
- A bubble is all controls 0, illegal=0 and rt=0.

Register stages:
- ID/EX holds the decoded controls, id_rt and illegal.
- EX/MEM takes mem_read, mem_write, reg_write and mem_to_reg from ID/EX.
- MEM/WB takes reg_write and mem_to_reg from EX/MEM.
- EX/MEM and MEM/WB advance every cycle. They are never stalled, so a bubble propagates naturally.

Counters:
- stall_cnt increments on each cycle with hazard & ~ex_redirect.
- flush_cnt increments on each cycle with ex_redirect.
- Both hold at all-ones and never wrap.

## Timing
- While rst=1: every register and counter clears immediately; pc_write=1, ifid_write=1, ifid_flush=0; all ex_/mem_/wb_ outputs and ex_illegal are 0.
- The first rising edge after rst deasserts performs normal capture.
- An instruction decoded in cycle N drives its ex_ controls in N+1, mem_ in N+2 and wb_ in N+3.
- pc_write, ifid_write and ifid_flush are combinational from the current inputs and the ID/EX state. They are valid in the same cycle.
- A load-use stall lasts exactly one cycle. In the next cycle ID/EX holds a bubble, so the hazard clears.
- Reset mid-stall or mid-flush: the pipeline is empty after reset and no stall is pending.

## Configuration
- LOAD_USE_STALL_EN defined: hazard detection operates as above.
- LOAD_USE_STALL_EN undefined: hazard is tied to 0. pc_write and ifid_write depend only on reset (1 always), stall_cnt stays 0, and software must insert NOPs after loads. Flush behaviour is unchanged.

## Test plan
- Reset: hold rst mid-stream with ID/EX loaded from an LW -> all ex_/mem_/wb_ outputs 0, counters 0, pc_write=1 while rst=1.
- Propagation: issue LW (opcode 35) in cycle 0 -> ex_alu_src=1 and ex_alu_op=00 in cycle 1; mem_read=1 in cycle 2; wb_reg_write=1 and wb_mem_to_reg=1 in cycle 3.
- Load-use: LW with rt=8, followed by R-format with rs=8 -> pc_write=0 and ifid_write=0 for one cycle; the EX stage carries a bubble (ex_alu_op=00, all controls 0); stall_cnt=1. Repeating with rt=0 produces no stall.
- Flush precedence: ex_redirect=1 in the same cycle as a load-use hazard -> ifid_flush=1, pc_write=1, a bubble enters ID/EX, flush_cnt increments and stall_cnt is unchanged.
- Illegal opcode 63 -> ex_illegal=1 for one cycle with all controls 0; a following ORI (opcode 13) gives ex_alu_op=11 and ex_zero_extnd=1.
- Saturation with CNT_W=2: four consecutive redirects -> flush_cnt reads 1, 2, 3, 3.
